switch_gpio_responder: RTL and testbench
========================================

Name: switch_gpio_responder

Overview:
- Memory-mapped input peripheral that responds to processor data-bus reads and writes, the bus-side counterpart of the processor's memory interface.
- Synchronizes and debounces the board switches.
- Captures rising edges in sticky, write-1-to-clear flags, with a maskable interrupt line.
- Sits beside the data memory on the shared DataAdr/WriteData/MemWrite bus; its ReadData is muxed into the processor read path by the memory decoder.

Parameters:
- N_SW, 10, number of switch inputs (1..32).
- BASE_ADDR, 32'h0000_0400, word-aligned base of the 16-byte register window.
- DEBOUNCE_CYCLES, 50000, clocks a synchronized input must differ from the debounced value before the debounced value is accepted (>=2).

Ports:
- clk  input  1  system clock, rising-edge.
- nreset  input  1  asynchronous active-low reset.
- switches  input  N_SW  raw asynchronous switch levels.
- MemWrite  input  1  bus write strobe, sampled on rising clk.
- DataAdr  input  32  bus byte address.
- WriteData  input  32  bus write data.
- ReadData  output  32  combinational read data; 0 when the address is outside the window.
- hit  output  1  combinational; 1 when DataAdr is inside [BASE_ADDR, BASE_ADDR+15].
- irq  output  1  registered-state-derived interrupt: OR of (EDGE & MASK).

Behaviour:
- Reset (nreset=0, asynchronous):
  - Clears the synchronizer flops, debounced value, all debounce counters, EDGE and MASK.
  - ReadData and irq therefore read 0 and stay 0 until nreset releases.
- Register map, word offset = DataAdr[3:2]; DataAdr[1:0] ignored:
  - 0x0 DATA: debounced switches, RO.
  - 0x4 EDGE: sticky rising-edge flags, W1C.
  - 0x8 RAW: synchronized, undebounced switches, RO.
  - 0xC MASK: interrupt enable per bit, RW.
  - Bits [31:N_SW] always read 0; writes to them are ignored.
- Reads: purely combinational from current register state, with zero-cycle latency as the single-cycle core requires. Reads have no side effects.
- Writes: take effect on the rising clk edge where MemWrite=1 and hit=1. Writes to DATA/RAW are ignored. Writes with hit=0 change nothing.
- Synchronizer: 2 flops per bit; RAW = second flop.
- Debounce, per bit, each cycle:
  - If RAW[i]==DATA[i]: counter[i] <= 0.
  - Else if counter[i]==DEBOUNCE_CYCLES-1: DATA[i] <= RAW[i], counter[i] <= 0.
  - Else: counter[i] <= counter[i]+1.
  - Counter width = $clog2(DEBOUNCE_CYCLES).
  - Any glitch back to the old level restarts the count.
- Latency: a switch held stable from clock edge k first appears in DATA after edge k+1+DEBOUNCE_CYCLES (2 synchronizer edges, then DEBOUNCE_CYCLES counting edges).
- Edge capture:
  - rise[i] = 1 on the cycle DATA[i] updates 0->1.
  - EDGE <= (EDGE & ~clr) | rise, where clr = WriteData[N_SW-1:0] when writing EDGE, else 0.
  - Simultaneous set and clear of the same bit: set wins; the bit stays 1.
  - Falling edges are not captured.
- irq: updates the cycle after EDGE or MASK changes, since it is combinational from the flops.
- Counters never wrap: they clear at the terminal count.
- Reset mid-count discards progress.

Test Plan:
1. Reset values (DEBOUNCE_CYCLES=4, N_SW=10): switches=10'h3FF during reset, release nreset -> immediately after release, reads of 0x400/0x404/0x40C return 0 and irq=0. RAW (0x408) = 0x3FF after 2 edges; DATA = 0x3FF after edge 6; EDGE = 0x3FF the same edge.
2. Debounce glitch: DATA=0, switches[0] toggles high for 3 cycles then low -> DATA stays 0 and EDGE stays 0. Then hold high for 6 cycles -> DATA=0x001 exactly at edge k+5.
3. W1C and priority:
   - With EDGE=0x005, write 0x404 <= 0x001 -> EDGE=0x004.
   - Write 0x404 <= 0x004 on the same edge bit 2 rises again -> EDGE stays 0x004.
4. Interrupt mask: EDGE=0x010, write 0x40C <= 0x010 -> irq=1 next cycle. Write 0x404 <= 0x010 -> irq=0. Falling edge of sw4 -> EDGE unchanged.
5. Decode: read 0x3FC and 0x410 -> ReadData=0, hit=0. Write 0x410 <= 0xFFFF_FFFF -> MASK unchanged. Write 0x400 <= 0x3FF -> DATA unchanged. Read 0x40E returns MASK (low bits ignored).
6. Async reset mid-operation: assert nreset low between clock edges while a counter=2 and EDGE=0x3 -> all state and irq clear without a clock edge. After release, the pending switch needs the full 2+DEBOUNCE_CYCLES again.

Source files
------------

// File: rtl/switch_gpio_responder.sv
// Memory-mapped switch input port: 2-flop synchronizer, per-bit debounce,
// sticky write-1-to-clear rising-edge flags and a maskable interrupt.
module switch_gpio_responder #(
  parameter int unsigned N_SW            = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0400,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N_SW-1:0] switches,
  input  logic            MemWrite,
  input  logic [31:0]     DataAdr,
  input  logic [31:0]     WriteData,
  output logic [31:0]     ReadData,
  output logic            hit,
  output logic            irq
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_EDGE = 2'd1;
  localparam logic [1:0] REG_RAW  = 2'd2;
  localparam logic [1:0] REG_MASK = 2'd3;

  logic [N_SW-1:0]  sync_q;
  logic [N_SW-1:0]  raw_q;
  logic [N_SW-1:0]  data_q, data_d;
  logic [N_SW-1:0]  edge_q, edge_d;
  logic [N_SW-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q [N_SW];
  logic [CNT_W-1:0] cnt_d [N_SW];

  logic [31:0]      offset_c;
  logic [1:0]       reg_sel_c;
  logic             wr_en_c;
  logic [N_SW-1:0]  wr_bits_c;
  logic [N_SW-1:0]  rise_c;
  logic [N_SW-1:0]  clr_c;
  logic             unused_bits_c;

  // Window decode on the offset from base, so any word-aligned base works.
  assign offset_c  = DataAdr - BASE_ADDR;
  assign hit       = (offset_c[31:4] == 28'd0);
  assign reg_sel_c = offset_c[3:2];
  assign wr_en_c   = MemWrite & hit;
  assign wr_bits_c = WriteData[N_SW-1:0];

  generate
    if (N_SW < 32) begin : g_unused_wide
      assign unused_bits_c = ^{offset_c[1:0], WriteData[31:N_SW]};
    end else begin : g_unused_full
      assign unused_bits_c = ^offset_c[1:0];
    end
  endgenerate

  // Debounce: count cycles RAW disagrees with DATA; accept at terminal count.
  always_comb begin
    data_d = data_q;
    cnt_d  = '{default: '0};
    for (int unsigned i = 0; i < N_SW; i++) begin
      if (raw_q[i] != data_q[i]) begin
        if (cnt_q[i] == CNT_TERM) begin
          data_d[i] = raw_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge flags: new rises are ORed in after the clear, so a set wins.
  always_comb begin
    rise_c = data_d & ~data_q;
    clr_c  = '0;
    mask_d = mask_q;
    if (wr_en_c && (reg_sel_c == REG_EDGE)) begin
      clr_c = wr_bits_c;
    end
    if (wr_en_c && (reg_sel_c == REG_MASK)) begin
      mask_d = wr_bits_c;
    end
    edge_d = (edge_q & ~clr_c) | rise_c;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '0;
      raw_q  <= '0;
      data_q <= '0;
      edge_q <= '0;
      mask_q <= '0;
      cnt_q  <= '{default: '0};
    end else begin
      sync_q <= switches;
      raw_q  <= sync_q;
      data_q <= data_d;
      edge_q <= edge_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  // Zero-latency read path, side-effect free.
  always_comb begin
    ReadData = '0;
    if (hit) begin
      case (reg_sel_c)
        REG_DATA: ReadData = 32'(data_q);
        REG_EDGE: ReadData = 32'(edge_q);
        REG_RAW:  ReadData = 32'(raw_q);
        REG_MASK: ReadData = 32'(mask_q);
        default:  ReadData = '0;
      endcase
    end
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_switch_gpio_responder.sv
// Scoreboard bench for switch_gpio_responder: directed scenarios followed by
// randomized switch/bus traffic checked against a history-based model.
module tb_switch_gpio_responder;

  localparam int unsigned NSW  = 10;
  localparam int unsigned DB   = 4;
  localparam logic [31:0] BASE = 32'h0000_0400;

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;
  } exp_t;

  logic            clk       = 1'b0;
  logic            nreset    = 1'b0;
  logic            MemWrite  = 1'b0;
  logic [NSW-1:0]  switches  = '0;
  logic [31:0]     DataAdr   = '0;
  logic [31:0]     WriteData = '0;
  logic [31:0]     ReadData;
  logic            hit;
  logic            irq;

  logic            rd_vld = 1'b0;
  logic            fin    = 1'b0;
  exp_t            sb[$];
  int              n_chk  = 0;
  int              n_pass = 0;

  // Reference state: switch pipeline, raw-sample history since reset, registers.
  logic [NSW-1:0]  m_s1   = '0;
  logic [NSW-1:0]  m_raw  = '0;
  logic [NSW-1:0]  m_data = '0;
  logic [NSW-1:0]  m_edge = '0;
  logic [NSW-1:0]  m_mask = '0;
  logic [NSW-1:0]  m_hist[$];

  switch_gpio_responder #(
    .N_SW(NSW), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .nreset(nreset), .switches(switches), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData),
    .hit(hit), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd15);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [NSW-1:0] v;
    if (!in_win(a)) return 32'd0;
    case (word_of(a))
      0:       v = m_data;
      1:       v = m_edge;
      2:       v = m_raw;
      default: v = m_mask;
    endcase
    return 32'(v);
  endfunction

  // A bit flips once the last DB raw samples all disagree with it.
  task automatic model_step();
    logic [NSW-1:0] nd;
    logic [NSW-1:0] clr;
    logic           settled;
    nd  = m_data;
    clr = '0;
    m_hist.push_back(m_raw);
    if (m_hist.size() > int'(DB)) void'(m_hist.pop_front());
    if (m_hist.size() == int'(DB)) begin
      for (int i = 0; i < int'(NSW); i++) begin
        settled = 1'b1;
        foreach (m_hist[j]) if (m_hist[j][i] == m_data[i]) settled = 1'b0;
        if (settled) nd[i] = ~m_data[i];
      end
    end
    if (MemWrite && in_win(DataAdr)) begin
      if (word_of(DataAdr) == 1) clr = WriteData[NSW-1:0];
      if (word_of(DataAdr) == 3) m_mask = WriteData[NSW-1:0];
    end
    m_edge = (m_edge & ~clr) | (nd & ~m_data);
    m_data = nd;
    m_raw  = m_s1;
    m_s1   = switches;
  endtask

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_s1 = '0; m_raw = '0; m_data = '0; m_edge = '0; m_mask = '0;
      m_hist.delete();
    end else begin
      model_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, req);
  endtask

  // Monitor: pops one expectation for every presented read.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rd_vld && sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.nm, "_rdata"}, ReadData, e.rdata);
      chk({e.nm, "_hit"}, 32'(hit), 32'(e.hit));
      chk({e.nm, "_irq"}, 32'(irq), 32'(e.irq));
    end
    if (fin) begin
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic post(input exp_t e);
    #1;
    sb.push_back(e);
    rd_vld = 1'b1;
    #2;
    rd_vld = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input string nm);
    exp_t e;
    @(negedge clk);
    MemWrite = 1'b0; DataAdr = a;
    #1;
    e.nm = nm; e.rdata = model_read(a); e.hit = in_win(a); e.irq = |(m_edge & m_mask);
    sb.push_back(e);
    rd_vld = 1'b1;
    #2;
    rd_vld = 1'b0;
  endtask

  task automatic rdk(input logic [31:0] a, input logic [31:0] v, input logic h,
                     input logic q, input string nm);
    exp_t e;
    @(negedge clk);
    MemWrite = 1'b0; DataAdr = a;
    e.nm = nm; e.rdata = v; e.hit = h; e.irq = q;
    post(e);
  endtask

  task automatic rd_rst(input logic [31:0] a, input string nm);
    exp_t e;
    @(negedge clk);
    MemWrite = 1'b0; DataAdr = a; nreset = 1'b0;
    e.nm = nm; e.rdata = 32'd0; e.hit = 1'b1; e.irq = 1'b0;
    post(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); MemWrite = 1'b0; end
  endtask

  task automatic set_sw(input logic [NSW-1:0] v);
    @(negedge clk); MemWrite = 1'b0; switches = v;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); MemWrite = 1'b1; DataAdr = a; WriteData = d;
  endtask

  task automatic rel();
    @(negedge clk); MemWrite = 1'b0; nreset = 1'b1;
  endtask

  initial begin
    // Reset values and power-up latency with all switches high.
    switches = 10'h3FF;
    rdk(32'h400, 32'h0, 1'b1, 1'b0, "t1_in_reset");
    rel();
    rdk(32'h400, 32'h000, 1'b1, 1'b0, "t1_data_e1");
    rdk(32'h408, 32'h3FF, 1'b1, 1'b0, "t1_raw_e2");
    rdk(32'h404, 32'h000, 1'b1, 1'b0, "t1_edge_e3");
    rdk(32'h40C, 32'h000, 1'b1, 1'b0, "t1_mask_e4");
    rdk(32'h400, 32'h000, 1'b1, 1'b0, "t1_data_e5");
    rdk(32'h400, 32'h3FF, 1'b1, 1'b0, "t1_data_e6");
    rdk(32'h404, 32'h3FF, 1'b1, 1'b0, "t1_edge_e7");

    // Glitch shorter than the debounce window is rejected.
    set_sw('0); idle(10); wr(32'h404, 32'h3FF);
    rdk(32'h404, 32'h000, 1'b1, 1'b0, "t2_cleared");
    set_sw(10'h001); idle(2); set_sw('0); idle(8);
    rdk(32'h400, 32'h000, 1'b1, 1'b0, "t2_glitch_data");
    rdk(32'h404, 32'h000, 1'b1, 1'b0, "t2_glitch_edge");
    set_sw(10'h001); idle(4);
    rdk(32'h400, 32'h000, 1'b1, 1'b0, "t2_k4");
    rdk(32'h400, 32'h001, 1'b1, 1'b0, "t2_k5");
    rd(32'h404, "t2_edge_model");

    // W1C and set-beats-clear.
    set_sw(10'h005); idle(8);
    rdk(32'h404, 32'h005, 1'b1, 1'b0, "t3_edge5");
    wr(32'h404, 32'h001);
    rdk(32'h404, 32'h004, 1'b1, 1'b0, "t3_w1c");
    set_sw(10'h001); idle(8);
    rdk(32'h400, 32'h001, 1'b1, 1'b0, "t3_fall2");
    set_sw(10'h005); idle(4); wr(32'h404, 32'h004);
    rdk(32'h404, 32'h004, 1'b1, 1'b0, "t3_set_wins");
    rdk(32'h400, 32'h005, 1'b1, 1'b0, "t3_data");

    // Interrupt masking and falling edges.
    wr(32'h404, 32'h3FF);
    set_sw(10'h015); idle(8);
    rdk(32'h404, 32'h010, 1'b1, 1'b0, "t4_edge4");
    wr(32'h40C, 32'h010);
    rdk(32'h404, 32'h010, 1'b1, 1'b1, "t4_irq_on");
    wr(32'h404, 32'h010);
    rdk(32'h404, 32'h000, 1'b1, 1'b0, "t4_irq_off");
    set_sw(10'h005); idle(8);
    rdk(32'h404, 32'h000, 1'b1, 1'b0, "t4_fall");
    rdk(32'h400, 32'h005, 1'b1, 1'b0, "t4_data");

    // Address decode edges.
    rdk(32'h3FC, 32'h0, 1'b0, 1'b0, "t5_below");
    rdk(32'h410, 32'h0, 1'b0, 1'b0, "t5_above");
    wr(32'h410, 32'hFFFF_FFFF);
    rdk(32'h40C, 32'h010, 1'b1, 1'b0, "t5_miss_wr");
    wr(32'h400, 32'h3FF);
    rdk(32'h400, 32'h005, 1'b1, 1'b0, "t5_ro_data");
    rdk(32'h40E, 32'h010, 1'b1, 1'b0, "t5_low_bits");

    // Asynchronous reset mid-count.
    wr(32'h404, 32'h3FF);
    set_sw(10'h004); idle(8);
    set_sw(10'h007); idle(8);
    wr(32'h40C, 32'h003);
    set_sw(10'h00F); idle(2);
    rdk(32'h404, 32'h003, 1'b1, 1'b1, "t6_pre");
    rd_rst(32'h404, "t6_async");
    idle(1); rel(); idle(4);
    rdk(32'h400, 32'h000, 1'b1, 1'b0, "t6_e5");
    rdk(32'h400, 32'h00F, 1'b1, 1'b0, "t6_e6");
    rdk(32'h404, 32'h00F, 1'b1, 1'b0, "t6_edge");

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 6))
        0, 1: begin set_sw(NSW'($urandom)); idle(int'($urandom_range(0, 6))); end
        2, 3: rd(BASE + 32'($urandom_range(0, 15)), "rnd_rd");
        4:    rd(BASE - 32'd8 + 32'($urandom_range(0, 31)), "rnd_rd_any");
        5:    wr(BASE + 32'(4 * $urandom_range(0, 3)), $urandom);
        default: wr(BASE + 32'd4, $urandom);
      endcase
    end
    idle(2);
    fin = 1'b1;
  end

endmodule
